// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared ROB sizing and entry type codes used by decoder and ROB.
package reorder_buffer_pkg;
  localparam int RB_DEPTH = 16;
  localparam int RB_TAG_W = $clog2(RB_DEPTH);
  localparam int RB_DATA_W = 32;
  typedef enum logic [2:0] {
    T_ALU    = 3'b000,
    T_BRANCH = 3'b001,
    T_STORE  = 3'b010,
    T_LOAD   = 3'b011,
    T_JUMP   = 3'b100
  } rob_type_e;
  function automatic logic writes_rf(rob_type_e t);
    return t == T_ALU || t == T_LOAD || t == T_JUMP;
  endfunction
  function automatic logic is_ctrl(rob_type_e t);
    return t == T_BRANCH || t == T_JUMP;
  endfunction
endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit buffer with three writeback ports and mispredict flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_DEPTH = RB_DEPTH,
  localparam int TW = $clog2(ROB_DEPTH),
  localparam int DW = RB_DATA_W,
  localparam int CW = $clog2(ROB_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          dec_enable,
  input  logic          dec_ready,
  input  logic [4:0]    dec_rd,
  input  logic [2:0]    dec_type,
  output logic [TW-1:0] rob_tag,
  output logic          rob_is_full,
  input  logic          alu_wb_valid,
  input  logic [TW-1:0] alu_wb_tag,
  input  logic [DW-1:0] alu_wb_value,
  input  logic          lsb_wb_valid,
  input  logic [TW-1:0] lsb_wb_tag,
  input  logic [DW-1:0] lsb_wb_value,
  input  logic          br_wb_valid,
  input  logic [TW-1:0] br_wb_tag,
  input  logic [DW-1:0] br_wb_value,
  input  logic          br_wb_mispredict,
  input  logic [DW-1:0] br_wb_target,
  output logic          rf_commit_valid,
  output logic [4:0]    rf_commit_rd,
  output logic [TW-1:0] rf_commit_tag,
  output logic [DW-1:0] rf_commit_value,
  output logic          store_commit_valid,
  output logic [TW-1:0] store_commit_tag,
  output logic          flush,
  output logic [DW-1:0] flush_pc
);
  logic [TW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [ROB_DEPTH-1:0] busy_q, busy_d, done_q, done_d, mis_q, mis_d;
  rob_type_e type_q [ROB_DEPTH];
  rob_type_e type_d [ROB_DEPTH];
  logic [4:0] rd_q [ROB_DEPTH];
  logic [4:0] rd_d [ROB_DEPTH];
  logic [DW-1:0] value_q [ROB_DEPTH];
  logic [DW-1:0] value_d [ROB_DEPTH];
  logic [DW-1:0] target_q [ROB_DEPTH];
  logic [DW-1:0] target_d [ROB_DEPTH];
  logic rf_valid_q, rf_valid_d, st_valid_q, st_valid_d, flush_q, flush_d;
  logic [4:0] rf_rd_q, rf_rd_d;
  logic [TW-1:0] rf_tag_q, rf_tag_d, st_tag_q, st_tag_d;
  logic [DW-1:0] rf_value_q, rf_value_d, flush_pc_q, flush_pc_d;
  logic alloc, commit;
  assign rob_tag = tail_q;
  assign rob_is_full = count_q == CW'(ROB_DEPTH);
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;
    busy_d = busy_q;
    done_d = done_q;
    mis_d = mis_q;
    type_d = type_q;
    rd_d = rd_q;
    value_d = value_q;
    target_d = target_q;
    rf_valid_d = 1'b0;
    rf_rd_d = '0;
    rf_tag_d = '0;
    rf_value_d = '0;
    st_valid_d = 1'b0;
    st_tag_d = '0;
    flush_d = 1'b0;
    flush_pc_d = '0;
    alloc = rdy && dec_enable && !rob_is_full;
    commit = rdy && busy_q[head_q] && done_q[head_q];
    if (rdy) begin
      if (alu_wb_valid && busy_q[alu_wb_tag]) begin
        done_d[alu_wb_tag] = 1'b1;
        value_d[alu_wb_tag] = alu_wb_value;
      end
      if (lsb_wb_valid && busy_q[lsb_wb_tag]) begin
        done_d[lsb_wb_tag] = 1'b1;
        value_d[lsb_wb_tag] = lsb_wb_value;
      end
      if (br_wb_valid && busy_q[br_wb_tag]) begin
        done_d[br_wb_tag] = 1'b1;
        value_d[br_wb_tag] = br_wb_value;
        mis_d[br_wb_tag] = br_wb_mispredict;
        target_d[br_wb_tag] = br_wb_target;
      end
      if (commit) begin
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        head_d = head_q + 1'b1;
        rf_valid_d = writes_rf(type_q[head_q]) && rd_q[head_q] != 5'd0;
        rf_rd_d = rf_valid_d ? rd_q[head_q] : '0;
        rf_tag_d = rf_valid_d ? head_q : '0;
        rf_value_d = rf_valid_d ? value_q[head_q] : '0;
        st_valid_d = type_q[head_q] == T_STORE;
        st_tag_d = st_valid_d ? head_q : '0;
        flush_d = is_ctrl(type_q[head_q]) && mis_q[head_q];
        flush_pc_d = flush_d ? target_q[head_q] : '0;
      end
      if (alloc) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = dec_ready;
        mis_d[tail_q] = 1'b0;
        type_d[tail_q] = rob_type_e'(dec_type);
        rd_d[tail_q] = dec_rd;
        value_d[tail_q] = '0;
        target_d[tail_q] = '0;
        tail_d = tail_q + 1'b1;
      end
      count_d = count_q + CW'(alloc) - CW'(commit);
      // A mispredict squashes everything younger, including this cycle's allocation.
      if (flush_d) begin
        busy_d = '0;
        done_d = '0;
        head_d = '0;
        tail_d = '0;
        count_d = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      busy_q <= '0;
      done_q <= '0;
      mis_q <= '0;
      rf_valid_q <= 1'b0;
      rf_rd_q <= '0;
      rf_tag_q <= '0;
      rf_value_q <= '0;
      st_valid_q <= 1'b0;
      st_tag_q <= '0;
      flush_q <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      busy_q <= busy_d;
      done_q <= done_d;
      mis_q <= mis_d;
      rf_valid_q <= rf_valid_d;
      rf_rd_q <= rf_rd_d;
      rf_tag_q <= rf_tag_d;
      rf_value_q <= rf_value_d;
      st_valid_q <= st_valid_d;
      st_tag_q <= st_tag_d;
      flush_q <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
    type_q <= type_d;
    rd_q <= rd_d;
    value_q <= value_d;
    target_q <= target_d;
  end
  assign rf_commit_valid = rf_valid_q;
  assign rf_commit_rd = rf_rd_q;
  assign rf_commit_tag = rf_tag_q;
  assign rf_commit_value = rf_value_q;
  assign store_commit_valid = st_valid_q;
  assign store_commit_tag = st_tag_q;
  assign flush = flush_q;
  assign flush_pc = flush_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios with hand-computed commit/flush expectations.
module tb_reorder_buffer;
  logic clk = 0, rst = 0, rdy = 1;
  logic dec_enable = 0, dec_ready = 0;
  logic [4:0] dec_rd = 0;
  logic [2:0] dec_type = 0;
  logic [3:0] rob_tag;
  logic rob_is_full;
  logic alu_wb_valid = 0, lsb_wb_valid = 0, br_wb_valid = 0, br_wb_mispredict = 0;
  logic [3:0] alu_wb_tag = 0, lsb_wb_tag = 0, br_wb_tag = 0;
  logic [31:0] alu_wb_value = 0, lsb_wb_value = 0, br_wb_value = 0, br_wb_target = 0;
  logic rf_commit_valid, store_commit_valid, flush;
  logic [4:0] rf_commit_rd;
  logic [3:0] rf_commit_tag, store_commit_tag;
  logic [31:0] rf_commit_value, flush_pc;
  int total = 0, bad = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .dec_enable(dec_enable), .dec_ready(dec_ready), .dec_rd(dec_rd), .dec_type(dec_type),
    .rob_tag(rob_tag), .rob_is_full(rob_is_full),
    .alu_wb_valid(alu_wb_valid), .alu_wb_tag(alu_wb_tag), .alu_wb_value(alu_wb_value),
    .lsb_wb_valid(lsb_wb_valid), .lsb_wb_tag(lsb_wb_tag), .lsb_wb_value(lsb_wb_value),
    .br_wb_valid(br_wb_valid), .br_wb_tag(br_wb_tag), .br_wb_value(br_wb_value),
    .br_wb_mispredict(br_wb_mispredict), .br_wb_target(br_wb_target),
    .rf_commit_valid(rf_commit_valid), .rf_commit_rd(rf_commit_rd),
    .rf_commit_tag(rf_commit_tag), .rf_commit_value(rf_commit_value),
    .store_commit_valid(store_commit_valid), .store_commit_tag(store_commit_tag),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic alloc(input logic [2:0] t, input logic [4:0] rd, input logic ready);
    dec_enable = 1;
    dec_type = t;
    dec_rd = rd;
    dec_ready = ready;
    tick();
    dec_enable = 0;
    dec_ready = 0;
  endtask

  task automatic alu_wb(input logic [3:0] tag, input logic [31:0] v);
    alu_wb_valid = 1;
    alu_wb_tag = tag;
    alu_wb_value = v;
    tick();
    alu_wb_valid = 0;
  endtask

  task automatic quiet_outputs(input string tag);
    check({tag, "_rfv"}, rf_commit_valid, 0);
    check({tag, "_stv"}, store_commit_valid, 0);
    check({tag, "_flush"}, flush, 0);
  endtask

  initial begin
    do_reset();
    check("rst_tag", rob_tag, 0);
    check("rst_full", rob_is_full, 0);
    quiet_outputs("rst");
    check("rst_rfval", rf_commit_value, 0);
    check("rst_fpc", flush_pc, 0);

    // single ALU op, writeback-to-commit latency
    alloc(3'b000, 5'd5, 0);
    check("a_tag", rob_tag, 1);
    alu_wb(0, 32'h1234);
    check("a_wb_nocommit", rf_commit_valid, 0);
    tick();
    check("a_rfv", rf_commit_valid, 1);
    check("a_rd", rf_commit_rd, 5);
    check("a_val", rf_commit_value, 32'h1234);
    check("a_ctag", rf_commit_tag, 0);
    tick();
    check("a_pulse", rf_commit_valid, 0);

    // fill to full, extra allocation ignored, wrap after one commit
    do_reset();
    for (int i = 0; i < 16; i++) alloc(3'b000, 5'd1, 0);
    check("f_full", rob_is_full, 1);
    check("f_tag", rob_tag, 0);
    alloc(3'b000, 5'd2, 1);
    check("f_still_full", rob_is_full, 1);
    check("f_no_commit", rf_commit_valid, 0);
    alu_wb(0, 32'h77);
    tick();
    check("f_commit", rf_commit_valid, 1);
    check("f_unfull", rob_is_full, 0);
    check("f_wrap_tag", rob_tag, 0);

    // out-of-order writeback, in-order commit
    do_reset();
    alloc(3'b000, 5'd1, 0);
    alloc(3'b011, 5'd2, 0);
    alloc(3'b000, 5'd3, 0);
    alu_wb(2, 32'h22);
    lsb_wb_valid = 1; lsb_wb_tag = 1; lsb_wb_value = 32'h11;
    tick();
    lsb_wb_valid = 0;
    alu_wb(0, 32'hA0);
    check("o_early", rf_commit_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("o_rfv", rf_commit_valid, 1);
      check("o_tag", rf_commit_tag, i);
      check("o_rd", rf_commit_rd, i + 1);
    end
    check("o_val2", rf_commit_value, 32'h22);
    tick();
    check("o_idle", rf_commit_valid, 0);

    // mispredicted branch with all three ports in one cycle
    do_reset();
    alloc(3'b001, 5'd0, 0);
    alloc(3'b000, 5'd6, 0);
    alloc(3'b000, 5'd7, 0);
    alu_wb_valid = 1; alu_wb_tag = 1; alu_wb_value = 32'h66;
    lsb_wb_valid = 1; lsb_wb_tag = 2; lsb_wb_value = 32'h77;
    br_wb_valid = 1; br_wb_tag = 0; br_wb_value = 32'h4; br_wb_mispredict = 1; br_wb_target = 32'h100;
    tick();
    alu_wb_valid = 0; lsb_wb_valid = 0; br_wb_valid = 0; br_wb_mispredict = 0;
    tick();
    check("b_flush", flush, 1);
    check("b_fpc", flush_pc, 32'h100);
    check("b_rfv", rf_commit_valid, 0);
    check("b_tag", rob_tag, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      quiet_outputs("b_after");
    end
    for (int i = 0; i < 15; i++) alloc(3'b000, 5'd1, 0);
    check("b_count0", rob_is_full, 0);
    alloc(3'b000, 5'd1, 0);
    check("b_count16", rob_is_full, 1);

    // store commit and writes to x0
    do_reset();
    alloc(3'b010, 5'd0, 0);
    alloc(3'b000, 5'd0, 1);
    alloc(3'b000, 5'd9, 1);
    lsb_wb_valid = 1; lsb_wb_tag = 0; lsb_wb_value = 0;
    tick();
    lsb_wb_valid = 0;
    tick();
    check("s_stv", store_commit_valid, 1);
    check("s_sttag", store_commit_tag, 0);
    check("s_rfv", rf_commit_valid, 0);
    tick();
    quiet_outputs("s_x0");
    tick();
    check("s_rd9", rf_commit_valid, 1);
    check("s_rd9_tag", rf_commit_tag, 2);
    check("s_rd9_stv", store_commit_valid, 0);

    // rdy low freezes allocation and commit
    do_reset();
    rdy = 0;
    alloc(3'b000, 5'd4, 1);
    check("r_tag_frozen", rob_tag, 0);
    rdy = 1;
    alloc(3'b000, 5'd4, 1);
    rdy = 0;
    tick();
    check("r_no_commit", rf_commit_valid, 0);
    rdy = 1;
    tick();
    check("r_commit", rf_commit_valid, 1);
    check("r_rd", rf_commit_rd, 4);

    // reset with pending entries beats a same-cycle writeback
    do_reset();
    for (int i = 0; i < 5; i++) alloc(3'b000, 5'(i + 1), 0);
    check("x_tag5", rob_tag, 5);
    rst = 1;
    alu_wb_valid = 1; alu_wb_tag = 0; alu_wb_value = 32'h5;
    tick();
    rst = 0;
    alu_wb_valid = 0;
    check("x_tag", rob_tag, 0);
    check("x_full", rob_is_full, 0);
    quiet_outputs("x_rst");
    for (int i = 0; i < 5; i++) alu_wb(4'(i), 32'h9);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("x_stale", rf_commit_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
